ball_motion: RTL and testbench

- Per-frame ball physics integrator feeding the map renderer's ballx/bally inputs.
- Position format: unsigned 11.5 fixed point.
- On a shot, latches the aim direction and launch speed, advances the ball once per video frame, decays speed by friction and reflects off screen edges.
- Reports rolling/stopped status to game control.

---
 rtl/golf_pkg.sv | 22 ++
 rtl/ball_motion_if.sv | 41 ++++
 rtl/ball_axis_step.sv | 46 ++++
 rtl/ball_motion.sv | 218 +++++++++++++++++++++
 tb/tb_ball_motion.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/golf_pkg.sv
// Shared definitions for the ball physics block: fixed-point format, the
// position type and the integrator state encoding.
// The SUNK state exists only when BALL_MOTION_HOLE_DETECT_EN is defined.
package golf_pkg;

  localparam int FRAC_BITS = 5;    // 11.5 unsigned position format
  localparam int Q8_ONE    = 256;  // 1.0 in the Q8 direction inputs

  typedef logic [15:0] position_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CALC  = 3'd2,
    S_APPLY = 3'd3
`ifdef BALL_MOTION_HOLE_DETECT_EN
    ,
    S_SUNK  = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/ball_motion_if.sv
// Shot/frame control and ball status bundle between game control and the
// ball integrator.
//   master : game control side (drives shot and frame inputs, reads status)
//   slave  : ball_motion side
// Signals:
//   frame_tick_in  one-cycle per-frame pulse (vertical blank)
//   shoot_in       one-cycle shot request
//   power_in       launch speed, sub-pixels per frame
//   cos_abs_in/cos_sign_in, sin_abs_in/sin_sign_in  aim direction, Q8
//   ballx, bally   11.5 fixed-point position
//   moving_out, stop_pulse_out, shot_count_out, sunk_out  status
interface ball_motion_if;
  import golf_pkg::*;

  logic        frame_tick_in;
  logic        shoot_in;
  logic [7:0]  power_in;
  logic [15:0] cos_abs_in;
  logic        cos_sign_in;
  logic [15:0] sin_abs_in;
  logic        sin_sign_in;
  position_t   ballx;
  position_t   bally;
  logic        moving_out;
  logic        stop_pulse_out;
  logic [7:0]  shot_count_out;
  logic        sunk_out;

  modport master (
    output frame_tick_in, shoot_in, power_in,
    output cos_abs_in, cos_sign_in, sin_abs_in, sin_sign_in,
    input  ballx, bally, moving_out, stop_pulse_out, shot_count_out, sunk_out
  );

  modport slave (
    input  frame_tick_in, shoot_in, power_in,
    input  cos_abs_in, cos_sign_in, sin_abs_in, sin_sign_in,
    output ballx, bally, moving_out, stop_pulse_out, shot_count_out, sunk_out
  );

endinterface

// File: rtl/ball_axis_step.sv
// One-axis position step with edge reflection (purely combinational).
// Ports:
//   pos       current position, 11.5 fixed point
//   delta     step magnitude this frame
//   dir_pos   1 = step towards larger coordinates
//   lo, hi    inclusive position bounds
//   pos_next  stepped position, clamped to [lo, hi]
//   dir_next  direction after the step (inverted when a bound was hit)
module ball_axis_step
  import golf_pkg::*;
(
  input  position_t pos,
  input  position_t delta,
  input  logic      dir_pos,
  input  position_t lo,
  input  position_t hi,
  output position_t pos_next,
  output logic      dir_next
);

  // 18-bit signed candidate so that an undershoot below zero stays negative
  // and an overshoot past 16 bits does not wrap.
  logic signed [17:0] pos_s;
  logic signed [17:0] delta_s;
  logic signed [17:0] lo_s;
  logic signed [17:0] hi_s;
  logic signed [17:0] cand;

  always_comb begin
    pos_s    = $signed({2'b00, pos});
    delta_s  = $signed({2'b00, delta});
    lo_s     = $signed({2'b00, lo});
    hi_s     = $signed({2'b00, hi});
    cand     = dir_pos ? (pos_s + delta_s) : (pos_s - delta_s);
    pos_next = cand[15:0];
    dir_next = dir_pos;
    if (cand < lo_s) begin
      pos_next = lo;
      dir_next = ~dir_pos;
    end else if (cand > hi_s) begin
      pos_next = hi;
      dir_next = ~dir_pos;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball physics integrator. A shot latches aim and power; each
// frame tick then runs CALC (scale speed by direction) and APPLY (step,
// reflect off edges, apply friction). Position feeds the map renderer.
// Ports:
//   pixel_clk_in  pixel clock
//   rst_in        asynchronous active-low reset
//   bus           ball_motion_if.slave (shot/frame inputs, position/status)
// Optional feature: define BALL_MOTION_HOLE_DETECT_EN to capture a slow
// ball near (HOLE_X, HOLE_Y) into the terminal SUNK state; otherwise
// sunk_out is tied low.
module ball_motion
  import golf_pkg::*;
#(
  parameter int SCREEN_W = 1280,
  parameter int SCREEN_H = 720,
  parameter int START_X  = 640,
  parameter int START_Y  = 360,
  parameter int FRICTION = 1,
  parameter int EDGE     = 4
`ifdef BALL_MOTION_HOLE_DETECT_EN
  ,
  parameter int HOLE_X         = 1100,
  parameter int HOLE_Y         = 360,
  parameter int HOLE_MAX_SPEED = 40
`endif
)(
  input logic         pixel_clk_in,
  input logic         rst_in,
  ball_motion_if.slave bus
);

  localparam position_t X_LO    = position_t'(EDGE << FRAC_BITS);
  localparam position_t X_HI    = position_t'((SCREEN_W - 1 - EDGE) << FRAC_BITS);
  localparam position_t Y_LO    = position_t'(EDGE << FRAC_BITS);
  localparam position_t Y_HI    = position_t'((SCREEN_H - 1 - EDGE) << FRAC_BITS);
  localparam position_t X_START = position_t'(START_X << FRAC_BITS);
  localparam position_t Y_START = position_t'(START_Y << FRAC_BITS);
  localparam logic [7:0] FRIC   = 8'(FRICTION);

  state_t      state, state_next;
  position_t   x_pos, y_pos;
  logic [7:0]  speed;
  logic [15:0] cos_abs_r, sin_abs_r;
  logic        cos_sign_r, sin_sign_r;
  position_t   dx_p1, dy_p1;
  logic        moving, stop_pulse, sunk;
  logic [7:0]  shot_count;

  logic        accept_shot, do_calc, do_apply, rest, capture;
  logic [23:0] prod_x, prod_y;
  logic [7:0]  speed_dec;
  position_t   x_step, y_step;
  logic        dir_x_next, dir_y_next;

  always_comb begin
    prod_x    = {16'd0, speed} * {8'd0, cos_abs_r};
    prod_y    = {16'd0, speed} * {8'd0, sin_abs_r};
    speed_dec = (speed > FRIC) ? (speed - FRIC) : 8'd0;
  end

  // y grows downwards, so sin_sign = 0 means stepping towards larger y.
  ball_axis_step u_step_x (
    .pos      (x_pos),
    .delta    (dx_p1),
    .dir_pos  (cos_sign_r),
    .lo       (X_LO),
    .hi       (X_HI),
    .pos_next (x_step),
    .dir_next (dir_x_next)
  );

  ball_axis_step u_step_y (
    .pos      (y_pos),
    .delta    (dy_p1),
    .dir_pos  (~sin_sign_r),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .pos_next (y_step),
    .dir_next (dir_y_next)
  );

`ifdef BALL_MOTION_HOLE_DETECT_EN
  localparam logic [10:0] HOLE_XI    = 11'(HOLE_X);
  localparam logic [10:0] HOLE_YI    = 11'(HOLE_Y);
  localparam logic [7:0]  HOLE_SPD   = 8'(HOLE_MAX_SPEED);
  localparam position_t   HOLE_POS_X = position_t'(HOLE_X << FRAC_BITS);
  localparam position_t   HOLE_POS_Y = position_t'(HOLE_Y << FRAC_BITS);

  function automatic logic near_hole(input logic [10:0] v, input logic [10:0] c);
    logic [10:0] diff;
    diff = (v >= c) ? (v - c) : (c - v);
    return diff <= 11'd3;
  endfunction

  logic hole_hit;
  // Checked on the post-step integer position against the pre-decay speed.
  assign hole_hit = near_hole(x_step[15:5], HOLE_XI) &&
                    near_hole(y_step[15:5], HOLE_YI) &&
                    (speed <= HOLE_SPD);
`endif

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept_shot = 1'b0;
    do_calc     = 1'b0;
    do_apply    = 1'b0;
    rest        = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        // A same-cycle frame tick is ignored here; motion starts on the next one.
        if (bus.shoot_in && (bus.power_in != 8'd0)) begin
          accept_shot = 1'b1;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.frame_tick_in) state_next = S_CALC;
      end
      S_CALC: begin
        do_calc    = 1'b1;
        state_next = S_APPLY;
      end
      S_APPLY: begin
        do_apply = 1'b1;
`ifdef BALL_MOTION_HOLE_DETECT_EN
        if (hole_hit) begin
          capture    = 1'b1;
          state_next = S_SUNK;
        end else
`endif
        if (speed_dec == 8'd0) begin
          rest       = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_WAIT;
        end
      end
`ifdef BALL_MOTION_HOLE_DETECT_EN
      S_SUNK: state_next = S_SUNK;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_pos      <= X_START;
      y_pos      <= Y_START;
      speed      <= 8'd0;
      cos_abs_r  <= 16'd0;
      cos_sign_r <= 1'b0;
      sin_abs_r  <= 16'd0;
      sin_sign_r <= 1'b0;
      dx_p1      <= 16'd0;
      dy_p1      <= 16'd0;
      moving     <= 1'b0;
      stop_pulse <= 1'b0;
      sunk       <= 1'b0;
      shot_count <= 8'd0;
    end else begin
      stop_pulse <= 1'b0;
      if (accept_shot) begin
        speed      <= bus.power_in;
        cos_abs_r  <= bus.cos_abs_in;
        cos_sign_r <= bus.cos_sign_in;
        sin_abs_r  <= bus.sin_abs_in;
        sin_sign_r <= bus.sin_sign_in;
        moving     <= 1'b1;
        if (shot_count != 8'hFF) shot_count <= shot_count + 8'd1;
      end
      // CALC -> p1: per-axis step magnitude, Q8 product truncated to 16 bits
      if (do_calc) begin
        dx_p1 <= prod_x[23:8];
        dy_p1 <= prod_y[23:8];
      end
      // APPLY: commit reflected position, direction and decayed speed
      if (do_apply) begin
        x_pos      <= x_step;
        y_pos      <= y_step;
        cos_sign_r <= dir_x_next;
        sin_sign_r <= ~dir_y_next;
        speed      <= speed_dec;
        if (rest) begin
          moving     <= 1'b0;
          stop_pulse <= 1'b1;
        end
`ifdef BALL_MOTION_HOLE_DETECT_EN
        if (capture) begin
          x_pos      <= HOLE_POS_X;
          y_pos      <= HOLE_POS_Y;
          speed      <= 8'd0;
          moving     <= 1'b0;
          stop_pulse <= 1'b1;
          sunk       <= 1'b1;
        end
`endif
      end
    end
  end

  assign bus.ballx          = x_pos;
  assign bus.bally          = y_pos;
  assign bus.moving_out     = moving;
  assign bus.stop_pulse_out = stop_pulse;
  assign bus.shot_count_out = shot_count;
`ifdef BALL_MOTION_HOLE_DETECT_EN
  assign bus.sunk_out       = sunk;
`else
  assign bus.sunk_out       = 1'b0;
`endif

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a table of single-frame shots from the
// reset position plus hand-written multi-frame sequences (full roll, wall
// bounce, ignored inputs, simultaneous shot/tick, mid-roll reset, counter
// saturation and, with BALL_MOTION_HOLE_DETECT_EN, hole capture).
module tb_ball_motion;
  import golf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        shoot = 1'b0;
  logic [7:0]  power = 8'd0;
  logic [15:0] cos_abs = 16'd0;
  logic        cos_sign = 1'b0;
  logic [15:0] sin_abs = 16'd0;
  logic        sin_sign = 1'b0;

  int checks = 0;
  int failures = 0;
  logic stop_seen;

  always #5 clk = ~clk;

  ball_motion_if bus_a ();
  ball_motion_if bus_b ();

  assign bus_a.frame_tick_in = tick;
  assign bus_a.shoot_in      = shoot;
  assign bus_a.power_in      = power;
  assign bus_a.cos_abs_in    = cos_abs;
  assign bus_a.cos_sign_in   = cos_sign;
  assign bus_a.sin_abs_in    = sin_abs;
  assign bus_a.sin_sign_in   = sin_sign;
  assign bus_b.frame_tick_in = tick;
  assign bus_b.shoot_in      = shoot;
  assign bus_b.power_in      = power;
  assign bus_b.cos_abs_in    = cos_abs;
  assign bus_b.cos_sign_in   = cos_sign;
  assign bus_b.sin_abs_in    = sin_abs;
  assign bus_b.sin_sign_in   = sin_sign;

  ball_motion dut_a (.pixel_clk_in(clk), .rst_in(rst_n), .bus(bus_a));
  ball_motion #(.START_X(10)) dut_b (.pixel_clk_in(clk), .rst_in(rst_n), .bus(bus_b));

`ifdef BALL_MOTION_HOLE_DETECT_EN
  ball_motion_if bus_c ();
  assign bus_c.frame_tick_in = tick;
  assign bus_c.shoot_in      = shoot;
  assign bus_c.power_in      = power;
  assign bus_c.cos_abs_in    = cos_abs;
  assign bus_c.cos_sign_in   = cos_sign;
  assign bus_c.sin_abs_in    = sin_abs;
  assign bus_c.sin_sign_in   = sin_sign;
  ball_motion #(.START_X(1098)) dut_c (.pixel_clk_in(clk), .rst_in(rst_n), .bus(bus_c));
`endif

  typedef struct {
    logic [7:0]  power;
    logic [15:0] cos_abs;
    logic        cos_sign;
    logic [15:0] sin_abs;
    logic        sin_sign;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
    logic        exp_moving;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0; shoot = 1'b0; power = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic shot(input logic [7:0] p, input logic [15:0] c, input logic cs,
                      input logic [15:0] s, input logic ss);
    @(negedge clk);
    shoot = 1'b1; power = p; cos_abs = c; cos_sign = cs; sin_abs = s; sin_sign = ss;
    @(negedge clk);
    shoot = 1'b0;
  endtask

  // One frame tick, then wait until the APPLY result is visible (T+3).
  task automatic tick_settle();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    stop_seen = stop_seen | bus_a.stop_pulse_out;
    repeat (2) begin
      @(negedge clk);
      stop_seen = stop_seen | bus_a.stop_pulse_out;
    end
  endtask

  initial begin
    vecs[0] = '{8'd64,  16'd256,   1'b1, 16'd0,     1'b0, 16'd20544, 16'd11520, 1'b1};
    vecs[1] = '{8'd100, 16'd128,   1'b0, 16'd221,   1'b1, 16'd20430, 16'd11434, 1'b1};
    vecs[2] = '{8'd255, 16'd181,   1'b1, 16'd181,   1'b0, 16'd20660, 16'd11700, 1'b1};
    vecs[3] = '{8'd1,   16'd256,   1'b0, 16'd256,   1'b0, 16'd20479, 16'd11521, 1'b0};
    vecs[4] = '{8'd200, 16'd0,     1'b1, 16'd256,   1'b1, 16'd20480, 16'd11320, 1'b1};
    vecs[5] = '{8'd255, 16'd1000,  1'b1, 16'd0,     1'b0, 16'd21476, 16'd11520, 1'b1};
    vecs[6] = '{8'd255, 16'd0,     1'b1, 16'd65535, 1'b0, 16'd20480, 16'd22880, 1'b1};
    vecs[7] = '{8'd255, 16'd65535, 1'b0, 16'd0,     1'b0, 16'd128,   16'd11520, 1'b1};
    vecs[8] = '{8'd255, 16'd65535, 1'b1, 16'd65535, 1'b1, 16'd40800, 16'd128,   1'b1};

    // Reset state
    do_reset();
    check("rst_ballx", bus_a.ballx, 32'h5000);
    check("rst_bally", bus_a.bally, 32'h2D00);
    check("rst_moving", bus_a.moving_out, 0);
    check("rst_shots", bus_a.shot_count_out, 0);
    check("rst_stop", bus_a.stop_pulse_out, 0);
    check("rst_sunk", bus_a.sunk_out, 0);

    // Single-frame shots from the reset position
    for (int i = 0; i < 9; i++) begin
      do_reset();
      shot(vecs[i].power, vecs[i].cos_abs, vecs[i].cos_sign, vecs[i].sin_abs, vecs[i].sin_sign);
      tick_settle();
      check($sformatf("vec%0d_x", i), bus_a.ballx, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), bus_a.bally, vecs[i].exp_y);
      check($sformatf("vec%0d_moving", i), bus_a.moving_out, vecs[i].exp_moving);
    end

    // Straight shot rolled to rest, with latency and stop-pulse timing
    do_reset();
    shot(8'd64, 16'd256, 1'b1, 16'd0, 1'b0);
    check("straight_moving_rise", bus_a.moving_out, 1);
    check("straight_shots", bus_a.shot_count_out, 1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    check("straight_latency_t2", bus_a.ballx, 32'h5000);
    @(negedge clk);
    check("straight_tick1_x", bus_a.ballx, 32'h5040);
    stop_seen = 1'b0;
    for (int i = 2; i <= 63; i++) tick_settle();
    check("straight_no_early_stop", stop_seen, 0);
    check("straight_still_moving", bus_a.moving_out, 1);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    check("straight_stop_not_early", bus_a.stop_pulse_out, 0);
    @(negedge clk);
    check("straight_final_x", bus_a.ballx, 22560);
    check("straight_stop_pulse", bus_a.stop_pulse_out, 1);
    check("straight_moving_fall", bus_a.moving_out, 0);
    @(negedge clk);
    check("straight_stop_one_cycle", bus_a.stop_pulse_out, 0);
    check("straight_final_shots", bus_a.shot_count_out, 1);

    // Left wall bounce on the START_X=10 instance
    do_reset();
    check("wall_rst_x", bus_b.ballx, 320);
    shot(8'd255, 16'd256, 1'b0, 16'd0, 1'b0);
    tick_settle();
    check("wall_tick1_x", bus_b.ballx, 128);
    tick_settle();
    check("wall_tick2_x", bus_b.ballx, 382);
    check("wall_y", bus_b.bally, 11520);

    // Shot while rolling is ignored
    do_reset();
    shot(8'd64, 16'd256, 1'b1, 16'd0, 1'b0);
    tick_settle();
    shot(8'd200, 16'd256, 1'b0, 16'd0, 1'b0);
    check("roll_shot_count", bus_a.shot_count_out, 1);
    tick_settle();
    check("roll_shot_traj", bus_a.ballx, 20607);

    // Zero-power shot in IDLE is ignored, and so is a tick while idle
    do_reset();
    shot(8'd0, 16'd256, 1'b1, 16'd0, 1'b0);
    check("zero_pow_moving", bus_a.moving_out, 0);
    check("zero_pow_shots", bus_a.shot_count_out, 0);
    tick_settle();
    check("zero_pow_x", bus_a.ballx, 32'h5000);
    shot(8'd64, 16'd256, 1'b1, 16'd0, 1'b0);
    check("zero_pow_then_accept", bus_a.shot_count_out, 1);

    // Shot and tick in the same cycle: motion waits for the next tick
    do_reset();
    @(negedge clk);
    shoot = 1'b1; tick = 1'b1; power = 8'd64;
    cos_abs = 16'd256; cos_sign = 1'b1; sin_abs = 16'd0; sin_sign = 1'b0;
    @(negedge clk);
    shoot = 1'b0; tick = 1'b0;
    repeat (3) @(negedge clk);
    check("simul_x_held", bus_a.ballx, 32'h5000);
    check("simul_moving", bus_a.moving_out, 1);
    tick_settle();
    check("simul_next_tick_x", bus_a.ballx, 32'h5040);

    // Asynchronous reset in the middle of a frame update
    do_reset();
    shot(8'd64, 16'd256, 1'b1, 16'd0, 1'b0);
    tick_settle();
    tick_settle();
    check("midrst_before_x", bus_a.ballx, 20607);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_async_x", bus_a.ballx, 32'h5000);
    check("midrst_async_moving", bus_a.moving_out, 0);
    check("midrst_async_shots", bus_a.shot_count_out, 0);
    stop_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      stop_seen = stop_seen | bus_a.stop_pulse_out;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      stop_seen = stop_seen | bus_a.stop_pulse_out;
    end
    check("midrst_no_stop", stop_seen, 0);
    check("midrst_x_held", bus_a.ballx, 32'h5000);

    // Shot counter saturates at 255
    do_reset();
    for (int i = 0; i < 256; i++) begin
      shot(8'd1, 16'd256, 1'b1, 16'd0, 1'b0);
      tick_settle();
      @(negedge clk);
    end
    check("shots_saturate", bus_a.shot_count_out, 255);

`ifdef BALL_MOTION_HOLE_DETECT_EN
    // Slow ball ending 2 px from the hole is captured
    do_reset();
    shot(8'd20, 16'd256, 1'b1, 16'd0, 1'b0);
    tick_settle();
    check("hole_x", bus_c.ballx, 1100 << 5);
    check("hole_y", bus_c.bally, 360 << 5);
    check("hole_sunk", bus_c.sunk_out, 1);
    check("hole_stop", bus_c.stop_pulse_out, 1);
    check("hole_moving", bus_c.moving_out, 0);
    shot(8'd50, 16'd256, 1'b0, 16'd0, 1'b0);
    check("hole_shot_ignored", bus_c.shot_count_out, 1);
    tick_settle();
    check("hole_x_held", bus_c.ballx, 1100 << 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
